// File: rtl/interrupt_controller.sv
// Four-source interrupt controller: edge-latched pending bits, software mask,
// fixed lowest-index-wins priority, CPU request/acknowledge handshake and a bus register window.
module interrupt_controller #(
  parameter logic [7:0] BASE_ADDR    = 8'hE0,
  parameter logic [3:0] INITIAL_MASK = 4'hF
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  logic [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [3:0] SRC_RAISE,
  output logic [3:0] SRC_ACK,
  output logic       CPU_IRQ,
  output logic [1:0] CPU_IRQ_ID,
  input  logic       CPU_IRQ_ACK
);

  typedef enum logic [1:0] {IDLE, REQ, ACKOUT} state_t;

  state_t     state;
  logic [3:0] pending;
  logic [3:0] mask;
  logic [3:0] raise_d;
  logic       rd_sel;
  logic [1:0] rd_off;

  logic [7:0] offset;
  logic       in_window;
  logic       wr_mask;
  logic       wr_clear;
  logic [3:0] new_edge;
  logic [3:0] eligible;
  logic [3:0] id_onehot;
  logic [3:0] ack_clear;
  logic [3:0] w1c;
  logic [1:0] winner;
  logic [7:0] rd_data;

  // Modular subtraction keeps the window test a single compare for any base.
  assign offset    = BUS_ADDR - BASE_ADDR;
  assign in_window = (offset < 8'd4);
  assign wr_mask   = BUS_WE && in_window && (offset[1:0] == 2'd1);
  assign wr_clear  = BUS_WE && in_window && (offset[1:0] == 2'd3);

  assign new_edge  = SRC_RAISE & ~raise_d;
  assign eligible  = pending & mask;
  assign id_onehot = 4'b0001 << CPU_IRQ_ID;
  assign ack_clear = (state == REQ && CPU_IRQ_ACK) ? id_onehot : 4'b0000;
  assign w1c       = wr_clear ? BUS_DATA[3:0] : 4'b0000;

  always_comb begin
    winner = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) winner = i[1:0];
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (rd_off)
      2'd0:    rd_data = {4'b0000, pending};
      2'd1:    rd_data = {4'b0000, mask};
      2'd2:    rd_data = {5'b00000, (state == REQ), CPU_IRQ_ID};
      default: rd_data = 8'h00;
    endcase
  end

  assign BUS_DATA = rd_sel ? rd_data : 8'bzzzz_zzzz;

  // New edges are OR-ed in after the clears so a same-cycle edge keeps its pending bit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      pending    <= 4'b0000;
      mask       <= INITIAL_MASK;
      raise_d    <= 4'b0000;
      rd_sel     <= 1'b0;
      rd_off     <= 2'd0;
      CPU_IRQ    <= 1'b0;
      CPU_IRQ_ID <= 2'd0;
      SRC_ACK    <= 4'b0000;
    end else begin
      raise_d <= SRC_RAISE;
      pending <= (pending & ~(ack_clear | w1c)) | new_edge;
      if (wr_mask) mask <= BUS_DATA[3:0];
      rd_sel <= in_window && (offset < 8'd3) && !BUS_WE;
      rd_off <= offset[1:0];

      case (state)
        IDLE: begin
          SRC_ACK <= 4'b0000;
          if (eligible != 4'b0000) begin
            CPU_IRQ_ID <= winner;
            CPU_IRQ    <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (CPU_IRQ_ACK) begin
            CPU_IRQ <= 1'b0;
            SRC_ACK <= id_onehot;
            state   <= ACKOUT;
          end
        end
        ACKOUT: begin
          SRC_ACK <= 4'b0000;
          state   <= IDLE;
        end
        default: begin
          CPU_IRQ <= 1'b0;
          SRC_ACK <= 4'b0000;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Bus-mapped interrupt controller between the peripherals (timer at 0xF0, others) and the microprocessor's interrupt input.
- Latches rising edges of up to 4 peripheral interrupt-raise lines into pending bits, applies a software mask and fixed priority, and presents one request with a source ID to the CPU.
- On CPU acknowledge, returns a one-cycle ACK pulse to the winning peripheral.

Parameters:
- BASE_ADDR, 8'hE0, base of the 4-byte register window.
- INITIAL_MASK, 4'hF, enable mask after reset (1 = source enabled).

Ports:
- CLK  input  1  system clock, 100 MHz.
- RESET  input  1  synchronous, active-high reset.
- BUS_DATA  inout  8  shared tristate data bus.
- BUS_ADDR  input  8  bus address.
- BUS_WE  input  1  bus write enable.
- SRC_RAISE  input  4  peripheral interrupt-raise levels; bit 0 = timer. Each is held high until acked.
- SRC_ACK  output  4  one-cycle acknowledge pulse to each peripheral.
- CPU_IRQ  output  1  interrupt request to the processor.
- CPU_IRQ_ID  output  2  index of the requesting source; valid while CPU_IRQ = 1.
- CPU_IRQ_ACK  input  1  processor acknowledge; single-cycle pulse.

Behaviour:
- Reset (synchronous, RESET = 1 at a CLK edge):
  - pending = 0, mask = INITIAL_MASK, raise_d = 0, state = IDLE.
  - CPU_IRQ = 0, CPU_IRQ_ID = 0, SRC_ACK = 0, read select = 0, BUS_DATA = Z.
  - Reset mid-request abandons the request; no ACK is issued.
- Edge detect:
  - raise_d <= SRC_RAISE each cycle.
  - new_edge = SRC_RAISE & ~raise_d.
  - Each new_edge bit sets its pending bit on the next edge. Masked sources still set pending.
- Eligibility and priority:
  - eligible = pending & mask.
  - Priority is fixed: lowest index wins (bit 0 highest).
- State machine, all registered:
  - IDLE:
    - If eligible != 0, latch winner into CPU_IRQ_ID, set CPU_IRQ = 1, go to REQ.
    - Latency is 2 cycles from the SRC_RAISE rising edge to CPU_IRQ = 1 (one cycle to pending, one to REQ).
  - REQ:
    - Holds CPU_IRQ = 1 and CPU_IRQ_ID stable until CPU_IRQ_ACK = 1.
    - A mask change or a higher-priority arrival does not withdraw or re-target the request.
    - On ACK: CPU_IRQ <= 0, pending[ID] <= 0, SRC_ACK[ID] <= 1, go to ACKOUT.
  - ACKOUT:
    - SRC_ACK[ID] is high for exactly this one cycle, then returns to 0.
    - Go to IDLE. Re-arbitration occurs in IDLE on the following edge, so the minimum gap between requests is 1 idle cycle.
- CPU_IRQ_ACK in IDLE or ACKOUT is ignored.
- Simultaneous events on the same bit in the same cycle: new_edge set wins over both ack clear and W1C clear; the pending bit stays 1.
- Register map (offset from BASE_ADDR):
  - +0 PENDING: read-only, {4'b0, pending}.
  - +1 MASK: read/write, low 4 bits. Writes take effect next cycle.
  - +2 ACTIVE: read-only, {5'b0, state==REQ, CPU_IRQ_ID}.
  - +3 CLEAR: write-only, write-1-to-clear pending bits (low 4). A W1C of the bit currently in REQ does not cancel the request.
- Writes occur on the cycle where BUS_ADDR matches and BUS_WE = 1.
- Reads:
  - read select and offset are registered from (BUS_ADDR in BASE..BASE+2) & ~BUS_WE.
  - BUS_DATA is driven from live register values while the registered select is high, otherwise Z.
  - Read data appears 1 cycle after the address is presented.
  - Offset +3 reads leave BUS_DATA at Z.
- Addresses outside BASE..BASE+3 have no effect.

Test Plan:
- Reset, then SRC_RAISE[0] rises at cycle 10 -> CPU_IRQ = 1 and CPU_IRQ_ID = 0 at cycle 12. Pulse CPU_IRQ_ACK -> SRC_ACK = 4'b0001 for exactly one cycle, CPU_IRQ = 0, PENDING reads 0x00.
- SRC_RAISE[3] and SRC_RAISE[1] rise in the same cycle -> first request has ID = 1. After its ack plus 1 idle cycle, second request has ID = 3. SRC_ACK pulses 0b0010 then 0b1000.
- Write MASK = 0x0E, then raise source 0 -> no CPU_IRQ, PENDING reads 0x01. Write MASK = 0x0F -> CPU_IRQ = 1 with ID 0 two cycles later.
- While in REQ with ID 2: raise source 0 and write CLEAR = 0x04 -> request stays ID 2 until ack. The next request is ID 0.
- Source edge on bit 1 in the same cycle as the CPU ack of ID 1 -> PENDING bit 1 remains set and a new request with ID 1 follows.
- RESET asserted while in REQ -> next cycle CPU_IRQ = 0, SRC_ACK = 0, PENDING = 0x00, MASK reads 0x0F. CPU_IRQ_ACK pulse in IDLE -> no SRC_ACK pulse.
